// File: rtl/icache_fill_ctrl_pkg.sv
// rtl/icache_fill_ctrl_pkg.sv - shared sizing, miss-table types and helpers for icache_fill_ctrl
package icache_fill_ctrl_pkg;

  localparam int NUM_MSHR    = 4;
  localparam int TAG_W       = 4;
  localparam int LINE_ADDR_W = 29;
  localparam int LINE_DATA_W = 64;
  localparam int MSHR_IDX_W  = $clog2(NUM_MSHR);

  typedef logic [TAG_W-1:0]       mem_tag_t;
  typedef logic [LINE_ADDR_W-1:0] line_addr_t;
  typedef logic [LINE_DATA_W-1:0] line_data_t;
  typedef logic [NUM_MSHR-1:0]    mshr_vec_t;

  typedef enum logic [1:0] {
    MSHR_FREE       = 2'd0,
    MSHR_WAIT_ISSUE = 2'd1,
    MSHR_WAIT_DATA  = 2'd2
  } mshr_state_t;

  typedef struct packed {
    mshr_state_t state;
    line_addr_t  line_addr;
    mem_tag_t    mem_tag;
    logic        is_prefetch;
  } mshr_entry_t;

  localparam mshr_entry_t MSHR_ENTRY_FREE = '{state: MSHR_FREE, line_addr: '0, mem_tag: '0, is_prefetch: 1'b0};

  // Isolates the lowest set bit; used to pick the lowest-index free entry.
  function automatic mshr_vec_t lowest_set(input mshr_vec_t v);
    return v & (~v + mshr_vec_t'(1));
  endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// rtl/icache_fill_ctrl_if.sv - miss, memory and fill signal bundle for icache_fill_ctrl
interface icache_fill_ctrl_if;
  import icache_fill_ctrl_pkg::*;

  logic [1:0]       miss_valid;
  line_addr_t [1:0] miss_addr;
  logic [1:0]       miss_ack;
  logic             flush;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  mem_tag_t         mem_req_tag;
  mem_tag_t         mem_resp_tag;
  line_data_t       mem_resp_data;
  logic             fill_valid;
  line_addr_t       fill_addr;
  line_data_t       fill_data;
  logic             full;

  modport master (
    output miss_valid, miss_addr, flush, mem_req_tag, mem_resp_tag, mem_resp_data,
    input  miss_ack, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, full
  );

  modport slave (
    input  miss_valid, miss_addr, flush, mem_req_tag, mem_resp_tag, mem_resp_data,
    output miss_ack, mem_req_valid, mem_req_addr, fill_valid, fill_addr, fill_data, full
  );

endinterface

// File: rtl/icache_fill_ctrl_rr_issue_arbiter.sv
// rtl/icache_fill_ctrl_rr_issue_arbiter.sv - round-robin one-hot grant over miss-table issue requests
module rr_issue_arbiter
  import icache_fill_ctrl_pkg::*;
(
  input  mshr_vec_t             i_req,
  input  logic [MSHR_IDX_W-1:0] i_ptr,
  output mshr_vec_t             o_grant
);

  logic [MSHR_IDX_W-1:0] w_idx;
  logic                  w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_MSHR; k++) begin
      w_idx = i_ptr + MSHR_IDX_W'(k);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - icache miss table, round-robin memory issue and line fill; ICACHE_PREFETCH_EN adds next-line prefetch
module icache_fill_ctrl
  import icache_fill_ctrl_pkg::*;
(
  input logic               clock,
  input logic               reset,
  icache_fill_ctrl_if.slave bus
);

  mshr_entry_t           r_mshr [NUM_MSHR];
  mshr_entry_t           w_mshr_nxt [NUM_MSHR];
  logic [MSHR_IDX_W-1:0] r_rr_ptr;
  logic                  r_fill_valid;
  line_addr_t            r_fill_addr;
  line_data_t            r_fill_data;
  logic                  r_full;

  mshr_vec_t             w_free, w_wait_issue, w_demand_wait, w_resp_hit;
  mshr_vec_t             w_match0, w_match1, w_issue_req, w_grant;
  mshr_vec_t             w_alloc0_oh, w_alloc1_oh, w_free1, w_alloc_pf_oh;
  logic                  w_req0, w_req1, w_need0, w_need1, w_same;
  logic                  w_issue_fire, w_full_nxt;
  logic [MSHR_IDX_W-1:0] w_grant_idx;
  line_addr_t            w_grant_addr, w_hit_addr, w_pf_addr;

  always_comb begin
    w_free        = '0;
    w_wait_issue  = '0;
    w_demand_wait = '0;
    w_resp_hit    = '0;
    w_match0      = '0;
    w_match1      = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      w_free[i]        = r_mshr[i].state == MSHR_FREE;
      w_wait_issue[i]  = r_mshr[i].state == MSHR_WAIT_ISSUE;
      w_demand_wait[i] = w_wait_issue[i] && !r_mshr[i].is_prefetch;
      w_resp_hit[i]    = r_mshr[i].state == MSHR_WAIT_DATA && bus.mem_resp_tag != '0
                         && r_mshr[i].mem_tag == bus.mem_resp_tag;
      // Completing entries still count as matches: the miss is covered by this cycle's fill.
      w_match0[i]      = !w_free[i] && r_mshr[i].line_addr == bus.miss_addr[0];
      w_match1[i]      = !w_free[i] && r_mshr[i].line_addr == bus.miss_addr[1];
    end
  end

  assign w_req0      = bus.miss_valid[0] && !bus.flush;
  assign w_req1      = bus.miss_valid[1] && !bus.flush;
  assign w_need0     = w_req0 && !(|w_match0);
  assign w_alloc0_oh = w_need0 ? lowest_set(w_free) : '0;
  assign w_same      = w_need0 && bus.miss_addr[1] == bus.miss_addr[0];
  assign w_need1     = w_req1 && !(|w_match1) && !w_same;
  assign w_free1     = w_free & ~w_alloc0_oh;
  assign w_alloc1_oh = w_need1 ? lowest_set(w_free1) : '0;

  assign bus.miss_ack[0] = w_req0 && ((|w_match0) || (|w_alloc0_oh));
  assign bus.miss_ack[1] = w_req1 && ((|w_match1) || (w_same && (|w_alloc0_oh)) || (|w_alloc1_oh));

  rr_issue_arbiter u_arb (
    .i_req   (w_issue_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_grant_idx  = '0;
    w_grant_addr = '0;
    w_hit_addr   = '0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (w_grant[i]) begin
        w_grant_idx  = MSHR_IDX_W'(i);
        w_grant_addr = r_mshr[i].line_addr;
      end
      if (w_resp_hit[i]) w_hit_addr = r_mshr[i].line_addr;
    end
  end

  assign bus.mem_req_valid = !bus.flush && (|w_issue_req);
  assign bus.mem_req_addr  = bus.mem_req_valid ? {w_grant_addr, 3'b000} : 32'h0;
  assign w_issue_fire      = bus.mem_req_valid && bus.mem_req_tag != '0;

`ifdef ICACHE_PREFETCH_EN
  logic       r_pf_pend;
  line_addr_t r_pf_addr;
  logic       w_grant_pf;
  logic       w_pf_present;
  mshr_vec_t  w_free2;

  always_comb begin
    w_grant_pf   = 1'b0;
    w_pf_present = ((|w_alloc0_oh) && bus.miss_addr[0] == r_pf_addr)
                || ((|w_alloc1_oh) && bus.miss_addr[1] == r_pf_addr);
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (w_grant[i]) w_grant_pf = r_mshr[i].is_prefetch;
      if (!w_free[i] && r_mshr[i].line_addr == r_pf_addr) w_pf_present = 1'b1;
    end
  end

  // Prefetch only takes what demand leaves over, and only issues when no demand is waiting.
  assign w_free2       = w_free1 & ~w_alloc1_oh;
  assign w_alloc_pf_oh = (r_pf_pend && !bus.flush && !w_pf_present) ? lowest_set(w_free2) : '0;
  assign w_pf_addr     = r_pf_addr;
  assign w_issue_req   = (|w_demand_wait) ? w_demand_wait : w_wait_issue;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pf_pend <= 1'b0;
      r_pf_addr <= '0;
    end else begin
      r_pf_pend <= w_issue_fire && !w_grant_pf;
      r_pf_addr <= w_grant_addr + line_addr_t'(1);
    end
  end
`else
  assign w_alloc_pf_oh = '0;
  assign w_pf_addr     = '0;
  assign w_issue_req   = w_demand_wait;
`endif

  always_comb begin
    w_full_nxt = 1'b1;
    for (int i = 0; i < NUM_MSHR; i++) begin
      w_mshr_nxt[i] = r_mshr[i];
      if (w_resp_hit[i]) w_mshr_nxt[i].state = MSHR_FREE;
      if (bus.flush && w_wait_issue[i]) w_mshr_nxt[i].state = MSHR_FREE;
      if (w_issue_fire && w_grant[i]) begin
        w_mshr_nxt[i].state   = MSHR_WAIT_DATA;
        w_mshr_nxt[i].mem_tag = bus.mem_req_tag;
      end
      if (w_alloc0_oh[i])
        w_mshr_nxt[i] = '{state: MSHR_WAIT_ISSUE, line_addr: bus.miss_addr[0], mem_tag: '0, is_prefetch: 1'b0};
      if (w_alloc1_oh[i])
        w_mshr_nxt[i] = '{state: MSHR_WAIT_ISSUE, line_addr: bus.miss_addr[1], mem_tag: '0, is_prefetch: 1'b0};
      if (w_alloc_pf_oh[i])
        w_mshr_nxt[i] = '{state: MSHR_WAIT_ISSUE, line_addr: w_pf_addr, mem_tag: '0, is_prefetch: 1'b1};
      if (w_mshr_nxt[i].state == MSHR_FREE) w_full_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) r_mshr[i] <= MSHR_ENTRY_FREE;
      r_rr_ptr     <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
      r_full       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) r_mshr[i] <= w_mshr_nxt[i];
      if (w_issue_fire) r_rr_ptr <= w_grant_idx + MSHR_IDX_W'(1);
      r_fill_valid <= |w_resp_hit;
      if (|w_resp_hit) begin
        r_fill_addr <= w_hit_addr;
        r_fill_data <= bus.mem_resp_data;
      end
      r_full <= w_full_nxt;
    end
  end

  assign bus.fill_valid = r_fill_valid;
  assign bus.fill_addr  = r_fill_addr;
  assign bus.fill_data  = r_fill_data;
  assign bus.full       = r_full;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - scoreboard bench for icache_fill_ctrl (demand build, or prefetch build with ICACHE_PREFETCH_EN)
module tb_icache_fill_ctrl;
  import icache_fill_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_fill_ctrl_if bus();

  icache_fill_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    line_addr_t addr;
    line_data_t data;
  } fill_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_req_q[$];
  fill_t       exp_fill_q[$];
  fill_t       mon_f;
  logic [31:0] mon_a;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic line_data_t dat(input int t);
    return line_data_t'(64'hA5A5_0000_0000_0000) + line_data_t'(t);
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.fill_valid === 1'b1) begin
        if (exp_fill_q.size() == 0) check_eq("fill_unexpected", 64'(bus.fill_valid), 64'h0);
        else begin
          mon_f = exp_fill_q.pop_front();
          check_eq("fill_addr", 64'(bus.fill_addr), 64'(mon_f.addr));
          check_eq("fill_data", bus.fill_data, mon_f.data);
        end
      end
      if (bus.mem_req_valid === 1'b1 && bus.mem_req_tag != '0) begin
        if (exp_req_q.size() == 0) check_eq("req_unexpected", 64'(bus.mem_req_valid), 64'h0);
        else begin
          mon_a = exp_req_q.pop_front();
          check_eq("req_addr", 64'(bus.mem_req_addr), 64'(mon_a));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    bus.miss_valid   = '0;
    bus.flush        = 1'b0;
    bus.mem_req_tag  = '0;
    bus.mem_resp_tag = '0;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_miss(input int p, input line_addr_t a);
    bus.miss_valid[p] = 1'b1;
    bus.miss_addr[p]  = a;
  endtask

  task automatic respond(input int t, input line_addr_t a);
    bus.mem_resp_tag  = mem_tag_t'(t);
    bus.mem_resp_data = dat(t);
    exp_fill_q.push_back('{addr: a, data: dat(t)});
  endtask

  initial begin
    bus.miss_valid    = '0;
    bus.miss_addr     = '0;
    bus.flush         = 1'b0;
    bus.mem_req_tag   = '0;
    bus.mem_resp_tag  = '0;
    bus.mem_resp_data = '0;

    sample();
    check_eq("rst_fill_valid", 64'(bus.fill_valid), 64'h0);
    check_eq("rst_req_valid", 64'(bus.mem_req_valid), 64'h0);
    check_eq("rst_miss_ack", 64'(bus.miss_ack), 64'h0);
    check_eq("rst_full", 64'(bus.full), 64'h0);
    tick();
    reset = 1'b0;

`ifdef ICACHE_PREFETCH_EN
    set_miss(0, 29'h1FFF_FFFF);
    exp_req_q.push_back(32'hFFFF_FFF8);
    sample(); check_eq("pf_ack", 64'(bus.miss_ack), 64'h1); tick();
    bus.mem_req_tag = 4'd1;
    sample(); check_eq("pf_demand_issue", 64'(bus.mem_req_valid), 64'h1); tick();
    sample(); check_eq("pf_alloc_cycle", 64'(bus.mem_req_valid), 64'h0); tick();
    exp_req_q.push_back(32'h0);
    bus.mem_req_tag = 4'd2;
    sample(); check_eq("pf_issue", 64'(bus.mem_req_valid), 64'h1); tick();
    sample(); check_eq("pf_no_chain", 64'(bus.mem_req_valid), 64'h0);
    respond(2, 29'h0); tick();
    respond(1, 29'h1FFF_FFFF); tick();
    tick();
    sample(); check_eq("pf_full_end", 64'(bus.full), 64'h0); tick();
`else
    // Single miss, tag 3, response five cycles after the miss.
    set_miss(0, 29'h100);
    exp_req_q.push_back(32'h800);
    sample();
    check_eq("t1_ack", 64'(bus.miss_ack), 64'h1);
    check_eq("t1_no_issue_alloc_cycle", 64'(bus.mem_req_valid), 64'h0);
    tick();
    bus.mem_req_tag = 4'd3;
    sample(); check_eq("t1_req_valid", 64'(bus.mem_req_valid), 64'h1); tick();
    for (int i = 0; i < 3; i++) begin
      sample(); check_eq("t1_idle", 64'(bus.mem_req_valid), 64'h0); tick();
    end
    bus.mem_resp_tag  = 4'd3;
    bus.mem_resp_data = 64'hDEAD_BEEF_0000_0001;
    exp_fill_q.push_back('{addr: 29'h100, data: 64'hDEAD_BEEF_0000_0001});
    sample(); check_eq("t1_fill_latency", 64'(bus.fill_valid), 64'h0); tick();
    sample(); check_eq("t1_fill_now", 64'(bus.fill_valid), 64'h1); tick();
    sample(); check_eq("t1_fill_one_cycle", 64'(bus.fill_valid), 64'h0); tick();

    // Same line on both ports, then a merge into the WAIT_DATA entry.
    set_miss(0, 29'h200); set_miss(1, 29'h200);
    exp_req_q.push_back(32'h1000);
    sample(); check_eq("t2_dual_ack", 64'(bus.miss_ack), 64'h3); tick();
    bus.mem_req_tag = 4'd4;
    sample(); check_eq("t2_req_valid", 64'(bus.mem_req_valid), 64'h1); tick();
    set_miss(0, 29'h200);
    sample();
    check_eq("t2_single_req", 64'(bus.mem_req_valid), 64'h0);
    check_eq("t2_merge_ack", 64'(bus.miss_ack), 64'h1);
    tick();
    sample(); check_eq("t2_no_new_alloc", 64'(bus.mem_req_valid), 64'h0);
    respond(4, 29'h200); tick();
    tick();

    // Four outstanding misses fill the table; a fifth waits for a free entry.
    for (int k = 0; k < 4; k++) begin
      set_miss(0, line_addr_t'(32'h300 + k));
      exp_req_q.push_back((32'h300 + k) << 3);
      sample(); check_eq("t3_ack", 64'(bus.miss_ack), 64'h1); tick();
      bus.mem_req_tag = mem_tag_t'(6 + k);
      sample(); check_eq("t3_req_valid", 64'(bus.mem_req_valid), 64'h1); tick();
    end
    set_miss(1, 29'h304);
    sample();
    check_eq("t3_full", 64'(bus.full), 64'h1);
    check_eq("t3_fifth_nack", 64'(bus.miss_ack), 64'h0);
    tick();
    set_miss(1, 29'h304);
    respond(6, 29'h300);
    sample(); check_eq("t3_freed_not_reusable", 64'(bus.miss_ack), 64'h0); tick();
    set_miss(1, 29'h304);
    exp_req_q.push_back(32'h1820);
    sample();
    check_eq("t3_fifth_ack", 64'(bus.miss_ack), 64'h2);
    check_eq("t3_not_full", 64'(bus.full), 64'h0);
    tick();
    bus.mem_req_tag = 4'd10;
    respond(7, 29'h301);
    sample(); check_eq("t3_full_again", 64'(bus.full), 64'h1); tick();
    respond(8, 29'h302); tick();
    respond(9, 29'h303); tick();
    respond(10, 29'h304); tick();
    tick();
    sample(); check_eq("t3_drained", 64'(bus.full), 64'h0); tick();

    // Memory rejects three times, then accepts with tag 5.
    set_miss(0, 29'h400);
    exp_req_q.push_back(32'h2000);
    sample(); check_eq("t4_ack", 64'(bus.miss_ack), 64'h1); tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_req_tag = 4'd5;
      sample();
      check_eq("t4_retry_valid", 64'(bus.mem_req_valid), 64'h1);
      check_eq("t4_retry_addr", 64'(bus.mem_req_addr), 64'h2000);
      tick();
    end
    bus.mem_resp_tag = 4'd2;
    sample(); check_eq("t4_no_reissue", 64'(bus.mem_req_valid), 64'h0); tick();
    sample(); check_eq("t4_foreign_tag", 64'(bus.fill_valid), 64'h0);
    respond(5, 29'h400); tick();
    tick();

    // Flush drops the two WAIT_ISSUE entries; the WAIT_DATA entry still fills.
    set_miss(0, 29'h500);
    exp_req_q.push_back(32'h2800);
    sample(); tick();
    bus.mem_req_tag = 4'd11;
    sample(); tick();
    set_miss(0, 29'h600); set_miss(1, 29'h601);
    sample(); check_eq("t5_two_acks", 64'(bus.miss_ack), 64'h3); tick();
    bus.flush = 1'b1;
    bus.mem_req_tag = 4'd12;
    set_miss(0, 29'h700);
    sample();
    check_eq("t5_flush_suppress", 64'(bus.mem_req_valid), 64'h0);
    check_eq("t5_flush_nack", 64'(bus.miss_ack), 64'h0);
    tick();
    sample(); check_eq("t5_flushed", 64'(bus.mem_req_valid), 64'h0);
    respond(11, 29'h500); tick();
    tick();

    // Reset while a request is outstanding; its later response is ignored.
    set_miss(0, 29'h800);
    exp_req_q.push_back(32'h4000);
    sample(); tick();
    bus.mem_req_tag = 4'd13;
    sample(); tick();
    reset = 1'b1;
    sample(); check_eq("t6_rst_req", 64'(bus.mem_req_valid), 64'h0); tick();
    reset = 1'b0;
    bus.mem_resp_tag = 4'd13;
    sample(); tick();
    sample();
    check_eq("t6_stale_resp", 64'(bus.fill_valid), 64'h0);
    check_eq("t6_full", 64'(bus.full), 64'h0);
    tick();
`endif

    check_eq("fill_q_drained", 64'(exp_fill_q.size()), 64'h0);
    check_eq("req_q_drained", 64'(exp_req_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
